// File: rtl/arb_pkg.sv
// Shared types and defaults for the arbiter requester front end.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } req_state_e;

  localparam int NUM_REQ_DEFAULT = 2;
  localparam int DEPTH_DEFAULT   = 7;
  localparam int TIMEOUT_DEFAULT = 16;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/arb_req_chan.sv
// One requester channel: pending count, IDLE/REQ/HOLD handshake with the
// arbiter, and the per-client served/overflow/timeout outputs.
module arb_req_chan
  import arb_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          grant_i,
  output logic          request_o,
  output logic          served_o,
  output logic [CW-1:0] count_o,
  output logic          overflow_o,
  output logic          timeout_o,
  output logic          idle_o
);

  localparam int            WW        = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [WW-1:0] TIMEOUT_C = WW'(TIMEOUT);

  req_state_e    state_q;
  logic [CW-1:0] count_q, count_d;
  logic [WW-1:0] wait_q;
  logic          served_q, overflow_q, timeout_q;
  logic          consume, push_ok;

  // A grant only counts while requesting; in HOLD it is the arbiter's stale echo.
  always_comb begin
    consume = (state_q == REQ) && grant_i;
    push_ok = push_i && ((count_q < DEPTH_C) || consume);
    count_d = count_q + CW'(push_ok) - CW'(consume);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      wait_q     <= '0;
      served_q   <= 1'b0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      count_q  <= count_d;
      served_q <= consume;
      if (push_i && !push_ok) overflow_q <= 1'b1;
      case (state_q)
        IDLE: begin
          wait_q <= '0;
          if ((count_q != '0) || push_i) state_q <= REQ;
        end
        REQ: begin
          if (grant_i) begin
            state_q <= HOLD;
            wait_q  <= '0;
          end else if (wait_q != TIMEOUT_C) begin
            wait_q <= wait_q + 1'b1;
            if (wait_q == TIMEOUT_C - 1'b1) timeout_q <= 1'b1;
          end
        end
        HOLD: begin
          wait_q  <= '0;
          state_q <= (count_d != '0) ? REQ : IDLE;
        end
        default: begin
          wait_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign request_o  = (state_q == REQ);
  assign idle_o     = (state_q == IDLE);
  assign served_o   = served_q;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;
  assign timeout_o  = timeout_q;

endmodule

// File: rtl/arb_req_gen.sv
// Requester stage for the fixed-priority arbiter: per-client channels plus
// grant fan-out, grant protocol checking and pending-count packing.
module arb_req_gen
  import arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int DEPTH   = DEPTH_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_REQ-1:0]                push,
  input  logic [NUM_REQ-1:0]                grant,
  output logic [NUM_REQ-1:0]                request,
  output logic [NUM_REQ-1:0]                served,
  output logic [NUM_REQ*cnt_width(DEPTH)-1:0] pending,
  output logic [NUM_REQ-1:0]                overflow_err,
  output logic [NUM_REQ-1:0]                timeout_err,
  output logic                              protocol_err
);

  localparam int CW = cnt_width(DEPTH);

  logic [NUM_REQ-1:0] idle_vec;
  logic               proto_hit;
  logic               protocol_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_chan
    arb_req_chan #(
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .CW      (CW)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push[gi]),
      .grant_i    (grant[gi]),
      .request_o  (request[gi]),
      .served_o   (served[gi]),
      .count_o    (pending[gi*CW +: CW]),
      .overflow_o (overflow_err[gi]),
      .timeout_o  (timeout_err[gi]),
      .idle_o     (idle_vec[gi])
    );
  end

  // Multiple grants, or a grant to a channel that never asked, is an arbiter fault.
  always_comb begin
    proto_hit = ($countones(grant) > 1) || (|(grant & idle_vec));
  end

  always_ff @(posedge clk) begin
    if (reset) protocol_q <= 1'b0;
    else if (proto_hit) protocol_q <= 1'b1;
  end

  assign protocol_err = protocol_q;

endmodule

// File: tb/tb_arb_req_gen.sv
// Scoreboard bench for arb_req_gen with a fixed-priority registered arbiter model.
module tb_arb_req_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] push = 2'b00;
  logic [1:0] grant;
  logic [1:0] request, served, overflow_err, timeout_err;
  logic [5:0] pending;
  logic       protocol_err;

  logic       force_en = 1'b0;
  logic [1:0] force_val = 2'b00;
  logic [1:0] arb_q;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  typedef struct {
    logic [1:0] mask;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  arb_req_gen dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .grant        (grant),
    .request      (request),
    .served       (served),
    .pending      (pending),
    .overflow_err (overflow_err),
    .timeout_err  (timeout_err),
    .protocol_err (protocol_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) arb_q <= 2'b00;
    else if (request[0]) arb_q <= 2'b01;
    else if (request[1]) arb_q <= 2'b10;
    else arb_q <= 2'b00;
  end

  assign grant = force_en ? force_val : arb_q;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  // Monitor: every served pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (served != 2'b00) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL served_unexpected: got %0h expected none (cycle %0d)", served, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("served_mask", int'(served), int'(e.mask));
        chk("served_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic expect_serve(input logic [1:0] mask, input int at);
    exp_t e;
    e.mask = mask;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  initial begin
    int e0;
    tick();
    do_reset();
    chk("rst_request", int'(request), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_errs", int'({overflow_err, timeout_err, protocol_err}), 0);

    // Single push to client0 with the arbiter in the loop
    push = 2'b01;
    tick();
    push = 2'b00;
    e0 = cyc;
    expect_serve(2'b01, e0 + 2);
    chk("t1_pending0_1", int'(pending[2:0]), 1);
    chk("t1_request_a", int'(request), 1);
    tick();
    chk("t1_request_b", int'(request), 1);
    tick();
    chk("t1_pending0_0", int'(pending[2:0]), 0);
    chk("t1_request_hold", int'(request), 0);
    tick();
    tick();
    chk("t1_request_idle", int'(request), 0);
    chk("t1_errs", int'({overflow_err, timeout_err, protocol_err}), 0);

    // Both clients at once: client0 first, then client1
    push = 2'b11;
    tick();
    push = 2'b00;
    e0 = cyc;
    expect_serve(2'b01, e0 + 2);
    expect_serve(2'b10, e0 + 4);
    chk("t2_request", int'(request), 3);
    repeat (7) tick();
    chk("t2_pending", int'(pending), 0);
    chk("t2_protocol", int'(protocol_err), 0);

    // Overflow on client1 with grants held off
    do_reset();
    force_en = 1'b1;
    force_val = 2'b00;
    for (int i = 0; i < 8; i++) begin
      push = 2'b10;
      tick();
      chk("t3_pending1", int'(pending[5:3]), (i + 1 > 7) ? 7 : i + 1);
      chk("t3_overflow", int'(overflow_err), (i == 7) ? 2 : 0);
    end
    push = 2'b10;
    force_val = 2'b10;
    expect_serve(2'b10, cyc + 1);
    tick();
    push = 2'b00;
    force_val = 2'b00;
    chk("t3_push_consume_full", int'(pending[5:3]), 7);
    tick();
    chk("t3_protocol", int'(protocol_err), 0);

    // Timeout on client0
    do_reset();
    force_val = 2'b00;
    push = 2'b01;
    tick();
    push = 2'b00;
    repeat (15) tick();
    chk("t4_timeout_pre", int'(timeout_err), 0);
    tick();
    chk("t4_timeout_set", int'(timeout_err), 1);
    chk("t4_request_kept", int'(request), 1);
    repeat (4) tick();
    chk("t4_timeout_sticky", int'(timeout_err), 1);
    chk("t4_request_still", int'(request), 1);

    // Protocol violations
    do_reset();
    chk("t5_clear", int'(protocol_err), 0);
    force_val = 2'b11;
    tick();
    force_val = 2'b00;
    chk("t5_multi_grant", int'(protocol_err), 1);
    do_reset();
    chk("t5_clear2", int'(protocol_err), 0);
    force_val = 2'b10;
    tick();
    force_val = 2'b00;
    chk("t5_grant_idle", int'(protocol_err), 1);

    // Mid-operation reset discards everything
    do_reset();
    push = 2'b11;
    tick();
    tick();
    push = 2'b01;
    tick();
    push = 2'b00;
    chk("t6_pending", int'(pending), (2 << 3) | 3);
    chk("t6_request", int'(request), 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    force_en = 1'b0;
    chk("t6_rst_pending", int'(pending), 0);
    chk("t6_rst_request", int'(request), 0);
    chk("t6_rst_outs", int'({served, overflow_err, timeout_err, protocol_err}), 0);
    push = 2'b01;
    tick();
    push = 2'b00;
    e0 = cyc;
    expect_serve(2'b01, e0 + 2);
    chk("t6_fresh_pending", int'(pending[2:0]), 1);
    repeat (4) tick();
    chk("t6_fresh_done", int'(pending), 0);
    chk("t6_errs", int'({overflow_err, timeout_err, protocol_err}), 0);

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
